turn_arbiter: RTL and testbench
===============================

Name: turn_arbiter

Overview:
- Front-end sequencer for the 6-player turn game core.
- Synchronises raw player buttons to the system clock, latches each player's 3-bit choice, and arbitrates simultaneous presses round-robin.
- Drives the core's per-player clock lines as clean, non-overlapping pulses, at most one player at a time.
- Enforces a turn timeout: if the active player does not press in time, it injects a forfeit press (choice 3'b000).

Parameters:
- NUM_PLAYERS, 6, number of players; the game core fixes this at 6.
- CHOICE_W, 3, width of one player's choice.
- PULSE_CYCLES, 2, clk cycles each player_clk pulse is held high.
- TIMEOUT_CYCLES, 1000, idle cycles allowed in a player's turn before forfeit; minimum 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn  in  6  raw, asynchronous press level per player; bit i is player i+1.
- choice_in  in  18  packed raw choices; player i uses bits [3i+2:3i].
- cur_state  in  4  game core state_out; 1..6 is that player's turn, bit3=1 means game over.
- player_clk  out  6  one-hot pulse bus to the game core clock inputs.
- choice_out  out  18  latched choices to the core's player1..player6 inputs.
- grant_id  out  3  player index 1..6 currently being served; 0 when idle.
- busy  out  1  high while a grant is in flight.
- timeout_pulse  out  1  one-cycle strobe when a forfeit is injected.

Behaviour:
- Reset values: player_clk=0, choice_out=0, grant_id=0, busy=0, timeout_pulse=0, pending=0, rr_ptr=0, timeout counter=0, FSM=IDLE.
- Input conditioning: each btn bit passes through a 2-FF synchroniser, then a rising-edge detector. A detected edge sets pending[i].
- Choice capture: on the same cycle the edge is detected, choice_in[i] (synchronised alongside btn) is captured into that player's 3-bit staging register.
- Pending is sticky. A press that arrives while busy is held until it is served. A repeat press by an already-pending player only updates the staged choice.
- FSM states: IDLE, SETUP, PULSE, GAP.
  - IDLE: if pending≠0, pick the first set bit scanning from rr_ptr+1 upward with wrap-around. Copy that player's staged choice into choice_out. Set grant_id, set busy, clear that pending bit, set rr_ptr to the winner, then go to SETUP.
  - SETUP: one cycle so choice_out is stable before the clock edge; go to PULSE.
  - PULSE: assert player_clk[winner] for exactly PULSE_CYCLES cycles; go to GAP.
  - GAP: player_clk=0 for 2 cycles so the core state can settle; then grant_id=0, busy=0, go to IDLE.
- Latency: a synchronised edge seen in IDLE produces player_clk high 2 cycles later. The minimum press-to-pulse delay from raw btn is 4 cycles.
- choice_out per player holds its last granted value until that player is next granted.
- Timeout counter:
  - Counts only while FSM=IDLE, pending=0, and cur_state is in 1..6.
  - Clears on any grant and on any change of cur_state.
  - On reaching TIMEOUT_CYCLES-1: set pending[cur_state-1], force that player's staged choice to 3'b000, pulse timeout_pulse, clear the counter.
- Game over (cur_state[3]=1, or cur_state=0): the counter is held at 0. Presses are still forwarded, so the core's own restart behaviour applies.
- Simultaneous timeout and real press by the same player: the real press wins; no forfeit is injected and no timeout_pulse is issued.
- Reset mid-pulse: player_clk drops on the reset edge and all pending presses are discarded.

Optional Feature:
- Macro: TURN_ARBITER_TURN_FILTER_EN.
- When defined: a press from a player whose index ≠ cur_state is dropped and never reaches the core, so no wrong-turn loss occurs.
- When undefined: all presses are forwarded and the core judges wrong turns.

Decomposition:
- Package turn_arbiter_pkg:
  - NUM_PLAYERS and CHOICE_W constants.
  - FSM state enum (IDLE, SETUP, PULSE, GAP).
  - FORFEIT_CHOICE = 3'b000.
  - GAME_OVER_BIT = 3.
- Sub-module btn_sync_edge: 2-FF synchroniser plus rising-edge pulse, instantiated 6 times.

Test Plan:
- Single press: cur_state=1; btn[0] rises with choice 3'b010 → 4 cycles later player_clk=6'b000001 for 2 cycles, choice_out[2:0]=010, grant_id=1, busy clears 2 cycles after the pulse ends.
- Simultaneous presses: btn[2] and btn[4] in the same cycle, rr_ptr=0 → player 3 is pulsed first, player 5 follows after GAP; the two pulses never overlap.
- Press while busy: btn[1] rises during PULSE of player 1 → held pending, then served immediately after GAP.
- Timeout: TIMEOUT_CYCLES=8, cur_state=4, no presses → after 8 idle cycles timeout_pulse=1, then player_clk[3] is pulsed with choice_out[11:9]=000.
- Reset mid-operation: reset during PULSE → next cycle player_clk=0, busy=0, pending=0; a queued btn press is lost.
- Turn filter (TURN_ARBITER_TURN_FILTER_EN defined): cur_state=2, btn[5] pressed → no pulse; btn[1] pressed → pulse on player_clk[1].

Source files
------------

// File: rtl/turn_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the turn arbiter front-end.
package turn_arbiter_pkg;

  localparam int unsigned NUM_PLAYERS = 6;
  localparam int unsigned CHOICE_W    = 3;
  localparam int unsigned ID_W        = 3;
  localparam int unsigned GAME_OVER_BIT = 3;

  localparam logic [CHOICE_W-1:0] FORFEIT_CHOICE = 3'b000;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StPulse,
    StGap
  } arb_state_e;

  // Returns the 1-based player of the first set request at or after player rr_ptr+1,
  // wrapping around; 0 when nothing is requested.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_PLAYERS-1:0] req,
                                              input logic [ID_W-1:0]        rr_ptr);
    logic [ID_W-1:0] winner;
    int unsigned     idx;
    winner = '0;
    // Walk farthest-first so the nearest requester is written last.
    for (int unsigned k = NUM_PLAYERS; k > 0; k--) begin
      idx = (32'(rr_ptr) + k - 1) % NUM_PLAYERS;
      if (req[idx]) winner = ID_W'(idx + 1);
    end
    return winner;
  endfunction

  // True when the core reports a live turn for one of the players.
  function automatic logic is_turn(input logic [3:0] cs);
    return !cs[GAME_OVER_BIT] && (cs[2:0] != 3'd0) && (cs[2:0] <= 3'(NUM_PLAYERS));
  endfunction

endpackage

// File: rtl/turn_arbiter_btn_sync.sv
// Two-flop synchroniser for one player's button and choice, plus a rising-edge strobe.
module btn_sync_edge
  import turn_arbiter_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                btn_i,
  input  logic [CHOICE_W-1:0] choice_i,
  output logic                rise_o,
  output logic [CHOICE_W-1:0] choice_o
);

  logic                btn_meta_q, btn_sync_q, btn_prev_q;
  logic [CHOICE_W-1:0] choice_meta_q, choice_sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      btn_prev_q    <= 1'b0;
      choice_meta_q <= '0;
      choice_sync_q <= '0;
    end else begin
      btn_meta_q    <= btn_i;
      btn_sync_q    <= btn_meta_q;
      btn_prev_q    <= btn_sync_q;
      choice_meta_q <= choice_i;
      choice_sync_q <= choice_meta_q;
    end
  end

  assign rise_o   = btn_sync_q & ~btn_prev_q;
  assign choice_o = choice_sync_q;

endmodule

// File: rtl/turn_arbiter.sv
// Button sequencer for the 6-player turn game core: sync, round-robin grant, clean clock pulses.
// Optional wrong-turn filtering is enabled by defining TURN_ARBITER_TURN_FILTER_EN.
module turn_arbiter
  import turn_arbiter_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PLAYERS-1:0]          btn,
  input  logic [NUM_PLAYERS*CHOICE_W-1:0] choice_in,
  input  logic [3:0]                      cur_state,
  output logic [NUM_PLAYERS-1:0]          player_clk,
  output logic [NUM_PLAYERS*CHOICE_W-1:0] choice_out,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy,
  output logic                            timeout_pulse
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned PhW  = (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [PhW-1:0]  PulseLast = PhW'(PULSE_CYCLES - 1);

  logic [NUM_PLAYERS-1:0]               rise, rise_f, turn_mask;
  logic [NUM_PLAYERS-1:0][CHOICE_W-1:0] choice_sync;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_sync
    btn_sync_edge u_sync (
      .clk_i    (clk),
      .reset_i  (reset),
      .btn_i    (btn[i]),
      .choice_i (choice_in[i*CHOICE_W +: CHOICE_W]),
      .rise_o   (rise[i]),
      .choice_o (choice_sync[i])
    );
  end

  logic       turn_valid;
  logic [2:0] turn_idx;

  assign turn_valid = is_turn(cur_state);
  assign turn_idx   = cur_state[2:0] - 3'd1;

`ifdef TURN_ARBITER_TURN_FILTER_EN
  // During game over every press passes so the core can restart.
  always_comb begin
    turn_mask = '1;
    if (turn_valid) turn_mask = NUM_PLAYERS'(1) << turn_idx;
  end
`else
  assign turn_mask = '1;
`endif

  assign rise_f = rise & turn_mask;

  arb_state_e                           state_q, state_d;
  logic [PhW-1:0]                       phase_q, phase_d;
  logic [NUM_PLAYERS-1:0]               pending_q, pending_d;
  logic [NUM_PLAYERS-1:0][CHOICE_W-1:0] stage_q, stage_d;
  logic [NUM_PLAYERS-1:0][CHOICE_W-1:0] choice_out_q, choice_out_d;
  logic [ID_W-1:0]                      grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic                                 busy_q, busy_d, timeout_q, timeout_d;
  logic [NUM_PLAYERS-1:0]               player_clk_q, player_clk_d;
  logic [TmoW-1:0]                      tmo_cnt_q, tmo_cnt_d;
  logic [3:0]                           cur_state_q;

  logic [NUM_PLAYERS-1:0] req, grant_mask, forfeit_mask;
  logic [ID_W-1:0]        pick, pick_idx, grant_idx_d;
  logic                   count_en, state_changed, fire;

  always_comb begin
    req           = pending_q | rise_f;
    pick          = rr_pick(req, rr_ptr_q);
    pick_idx      = pick - 3'd1;
    state_changed = cur_state != cur_state_q;
    // A real press in this cycle makes req non-zero, so it always beats the forfeit.
    count_en      = (state_q == StIdle) && (req == '0) && turn_valid;
    fire          = count_en && !state_changed && (tmo_cnt_q == TmoLast);

    state_d      = state_q;
    phase_d      = phase_q;
    stage_d      = stage_q;
    choice_out_d = choice_out_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    busy_d       = busy_q;
    timeout_d    = fire;
    grant_mask   = '0;
    forfeit_mask = '0;

    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (rise_f[i]) stage_d[i] = choice_sync[i];
    end
    if (fire) begin
      forfeit_mask           = NUM_PLAYERS'(1) << turn_idx;
      stage_d[turn_idx]      = FORFEIT_CHOICE;
    end

    unique case (state_q)
      StIdle: begin
        if (req != '0) begin
          grant_d    = pick;
          rr_ptr_d   = pick;
          busy_d     = 1'b1;
          grant_mask = NUM_PLAYERS'(1) << pick_idx;
          // Same-cycle edge bypasses the staging register.
          choice_out_d[pick_idx] = rise_f[pick_idx] ? choice_sync[pick_idx] : stage_q[pick_idx];
          state_d    = StSetup;
        end
      end
      StSetup: begin
        phase_d = '0;
        state_d = StPulse;
      end
      StPulse: begin
        if (phase_q == PulseLast) begin
          phase_d = '0;
          state_d = StGap;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StGap: begin
        if (phase_q == PhW'(1)) begin
          phase_d = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
    endcase

    pending_d = (pending_q | rise_f | forfeit_mask) & ~grant_mask;

    grant_idx_d  = grant_d - 3'd1;
    player_clk_d = (state_d == StPulse) ? (NUM_PLAYERS'(1) << grant_idx_d) : '0;

    if ((grant_mask != '0) || state_changed || !turn_valid || fire) begin
      tmo_cnt_d = '0;
    end else if (count_en) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    cur_state_q <= cur_state;
    if (reset) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      pending_q    <= '0;
      stage_q      <= '0;
      choice_out_q <= '0;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      player_clk_q <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pending_q    <= pending_d;
      stage_q      <= stage_d;
      choice_out_q <= choice_out_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      player_clk_q <= player_clk_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign player_clk    = player_clk_q;
  assign choice_out    = choice_out_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_turn_arbiter.sv
// Directed bench for turn_arbiter with PULSE_CYCLES=2 and TIMEOUT_CYCLES=8.
module tb_turn_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  btn;
  logic [17:0] choice_in;
  logic [3:0]  cur_state;
  logic [5:0]  player_clk;
  logic [17:0] choice_out;
  logic [2:0]  grant_id;
  logic        busy;
  logic        timeout_pulse;

  int checks   = 0;
  int failures = 0;
  int activity;

  turn_arbiter #(
    .PULSE_CYCLES   (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .choice_in     (choice_in),
    .cur_state     (cur_state),
    .player_clk    (player_clk),
    .choice_out    (choice_out),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    btn       = '0;
    choice_in = '0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    cur_state = 4'd1;
    do_reset();
    chk("rst_player_clk", 32'(player_clk), 32'h0);
    chk("rst_choice_out", 32'(choice_out), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout_pulse), 32'h0);

    // Single press by player 1.
    btn[0] = 1'b1;
    choice_in[2:0] = 3'b010;
    tick(2);
    chk("p1_not_yet_busy", 32'(busy), 32'h0);
    tick(1);
    btn = '0;
    chk("p1_busy", 32'(busy), 32'h1);
    chk("p1_grant", 32'(grant_id), 32'h1);
    chk("p1_choice", 32'(choice_out[2:0]), 32'h2);
    chk("p1_setup_clk_low", 32'(player_clk), 32'h0);
    tick(1);
    chk("p1_pulse_a", 32'(player_clk), 32'h01);
    tick(1);
    chk("p1_pulse_b", 32'(player_clk), 32'h01);
    tick(1);
    chk("p1_gap_clk", 32'(player_clk), 32'h0);
    chk("p1_gap_busy", 32'(busy), 32'h1);
    tick(1);
    chk("p1_gap2_busy", 32'(busy), 32'h1);
    tick(1);
    chk("p1_done_busy", 32'(busy), 32'h0);
    chk("p1_done_grant", 32'(grant_id), 32'h0);

    // Simultaneous presses by players 3 and 5.
    cur_state = 4'd0;
    do_reset();
    btn = 6'b010100;
    choice_in[8:6]   = 3'b011;
    choice_in[14:12] = 3'b110;
    tick(3);
    btn = '0;
    chk("sim_grant_first", 32'(grant_id), 32'h3);
    chk("sim_choice3", 32'(choice_out[8:6]), 32'h3);
    tick(1);
    chk("sim_pulse3", 32'(player_clk), 32'h04);
    tick(2);
    chk("sim_gap_clk", 32'(player_clk), 32'h0);
    tick(2);
    chk("sim_idle_clk", 32'(player_clk), 32'h0);
    chk("sim_idle_busy", 32'(busy), 32'h0);
    tick(1);
    chk("sim_grant_second", 32'(grant_id), 32'h5);
    chk("sim_choice5", 32'(choice_out[14:12]), 32'h6);
    tick(1);
    chk("sim_pulse5", 32'(player_clk), 32'h10);
    tick(2);
    chk("sim_pulse5_end", 32'(player_clk), 32'h0);

    // Press by player 2 while player 1 is being pulsed.
    cur_state = 4'd0;
    do_reset();
    btn[0] = 1'b1;
    choice_in[2:0] = 3'b101;
    tick(4);
    chk("busy_p1_pulse", 32'(player_clk), 32'h01);
    btn = 6'b000010;
    choice_in[5:3] = 3'b110;
    tick(3);
    chk("busy_gap_grant", 32'(grant_id), 32'h1);
    chk("busy_gap_clk", 32'(player_clk), 32'h0);
    tick(1);
    chk("busy_idle", 32'(busy), 32'h0);
    tick(1);
    btn = '0;
    chk("busy_grant2", 32'(grant_id), 32'h2);
    chk("busy_choice2", 32'(choice_out[5:3]), 32'h6);
    chk("busy_choice1_held", 32'(choice_out[2:0]), 32'h5);
    tick(1);
    chk("busy_pulse2", 32'(player_clk), 32'h02);

    // Timeout for player 4 after a real press left a nonzero choice.
    cur_state = 4'd0;
    do_reset();
    btn[3] = 1'b1;
    choice_in[11:9] = 3'b111;
    tick(3);
    btn = '0;
    chk("tmo_prior_choice", 32'(choice_out[11:9]), 32'h7);
    tick(5);
    chk("tmo_prior_done", 32'(busy), 32'h0);
    cur_state = 4'd4;
    tick(8);
    chk("tmo_early", 32'(timeout_pulse), 32'h0);
    tick(1);
    chk("tmo_pulse", 32'(timeout_pulse), 32'h1);
    chk("tmo_pulse_idle", 32'(busy), 32'h0);
    tick(1);
    chk("tmo_pulse_once", 32'(timeout_pulse), 32'h0);
    chk("tmo_grant", 32'(grant_id), 32'h4);
    chk("tmo_forfeit_choice", 32'(choice_out[11:9]), 32'h0);
    tick(1);
    chk("tmo_player_clk", 32'(player_clk), 32'h08);

    // Reset during a pulse discards the queued press by player 3.
    cur_state = 4'd0;
    do_reset();
    btn[0] = 1'b1;
    tick(1);
    btn[2] = 1'b1;
    tick(3);
    chk("rmid_pulse", 32'(player_clk), 32'h01);
    btn   = '0;
    reset = 1'b1;
    tick(1);
    chk("rmid_clk_drop", 32'(player_clk), 32'h0);
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_grant", 32'(grant_id), 32'h0);
    reset    = 1'b0;
    activity = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (busy !== 1'b0 || player_clk !== 6'b0) activity++;
    end
    chk("rmid_queue_lost", 32'(activity), 32'h0);

    // Players 2 and 6 press together during player 2's turn.
    cur_state = 4'd2;
    do_reset();
    btn = 6'b100010;
    choice_in[5:3]   = 3'b001;
    choice_in[17:15] = 3'b111;
    tick(3);
    btn = '0;
    chk("filt_grant2", 32'(grant_id), 32'h2);
    chk("filt_choice2", 32'(choice_out[5:3]), 32'h1);
    tick(1);
    chk("filt_pulse2", 32'(player_clk), 32'h02);
    tick(5);
`ifdef TURN_ARBITER_TURN_FILTER_EN
    chk("filt_p6_dropped_busy", 32'(busy), 32'h0);
    chk("filt_p6_dropped_grant", 32'(grant_id), 32'h0);
    tick(1);
    chk("filt_p6_no_pulse", 32'(player_clk), 32'h0);
`else
    chk("filt_p6_forwarded", 32'(grant_id), 32'h6);
    chk("filt_p6_choice", 32'(choice_out[17:15]), 32'h7);
    tick(1);
    chk("filt_p6_pulse", 32'(player_clk), 32'h20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
